// File: rtl/nanov_spi_ram_if.sv
// SPI target bus plus backdoor load port for the nanoV SPI RAM.
interface nanov_spi_ram_if #(
    parameter int unsigned ADDR_W = 8
) ();
    logic              spi_select;
    logic              spi_mosi;
    logic              spi_miso;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [7:0]        load_data;
    logic              busy;

    modport master (
        output spi_select, spi_mosi, load_en, load_addr, load_data,
        input  spi_miso, busy
    );

    modport slave (
        input  spi_select, spi_mosi, load_en, load_addr, load_data,
        output spi_miso, busy
    );
endinterface

// File: rtl/nanov_spi_ram.sv
// SPI RAM responder serving READ (0x03) / WRITE (0x02) from an internal byte array.
// Optional FAST READ (0x0B, 8 dummy cycles) enabled by NANOV_SPI_FAST_READ_EN.
module nanov_spi_ram #(
    parameter int unsigned MEM_BYTES = 256,
    parameter int unsigned ADDR_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    nanov_spi_ram_if.slave        bus
);
    localparam int unsigned KW = 6;

    localparam logic [7:0] OPC_READ  = 8'h03;
    localparam logic [7:0] OPC_WRITE = 8'h02;
`ifdef NANOV_SPI_FAST_READ_EN
    localparam logic [7:0] OPC_FAST  = 8'h0B;
`endif

    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_FAST  = 2'd2;

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR, FASTDUMMY, RDATA, WDATA, IGNORE
    } state_t;

    state_t            state_q, state_d;
    logic [KW-1:0]     k_q, k_d;
    logic [6:0]        sh_q, sh_d;
    logic [6:0]        rd_q, rd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        op_q, op_d;
    logic              miso_q, miso_d;
    logic              busy_q;
    logic              wr_en_c;
    logic [7:0]        wdata_c;

    logic [7:0]        mem [MEM_BYTES];

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            sh_q    <= '0;
            rd_q    <= '0;
            addr_q  <= '0;
            op_q    <= OP_READ;
            miso_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            sh_q    <= sh_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            op_q    <= op_d;
            miso_q  <= miso_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    // Byte array: backdoor first so a same-edge SPI write to the same byte wins
    always_ff @(posedge clk) begin
        if (bus.load_en) begin
            mem[bus.load_addr] <= bus.load_data;
        end
        if (wr_en_c && !rst) begin
            mem[addr_q] <= wdata_c;
        end
    end

    // Next-state, shift registers and serial output
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        sh_d    = sh_q;
        rd_d    = rd_q;
        addr_d  = addr_q;
        op_d    = op_q;
        miso_d  = 1'b0;
        wr_en_c = 1'b0;
        wdata_c = {sh_q, bus.spi_mosi};

        if (bus.spi_select) begin
            state_d = IDLE;
            k_d     = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // First low edge already carries opcode bit 7
                    sh_d    = {6'd0, bus.spi_mosi};
                    k_d     = KW'(1);
                    state_d = CMD;
                end
                CMD: begin
                    sh_d = {sh_q[5:0], bus.spi_mosi};
                    k_d  = k_q + KW'(1);
                    if (k_q == KW'(7)) begin
                        case ({sh_q, bus.spi_mosi})
                            OPC_READ:  begin op_d = OP_READ;  state_d = ADDR; end
                            OPC_WRITE: begin op_d = OP_WRITE; state_d = ADDR; end
`ifdef NANOV_SPI_FAST_READ_EN
                            OPC_FAST:  begin op_d = OP_FAST;  state_d = ADDR; end
`endif
                            default:   state_d = IGNORE;
                        endcase
                    end
                end
                ADDR: begin
                    // Upper address bits fall off the top of the shifter
                    addr_d = {addr_q[ADDR_W-2:0], bus.spi_mosi};
                    k_d    = k_q + KW'(1);
                    if (k_q == KW'(31)) begin
                        case (op_q)
                            OP_WRITE: state_d = WDATA;
                            OP_FAST:  state_d = FASTDUMMY;
                            default: begin
                                state_d = RDATA;
                                rd_d    = mem[addr_d][6:0];
                                miso_d  = mem[addr_d][7];
                            end
                        endcase
                    end
                end
                FASTDUMMY: begin
                    k_d = k_q + KW'(1);
                    if (k_q == KW'(39)) begin
                        state_d = RDATA;
                        k_d     = KW'(32);
                        rd_d    = mem[addr_q][6:0];
                        miso_d  = mem[addr_q][7];
                    end
                end
                RDATA: begin
                    // k stays in 32..39; its low bits index the bit within the byte
                    k_d = {3'b100, 3'(k_q[2:0] + 3'd1)};
                    if (k_q[2:0] == 3'd7) begin
                        addr_d = addr_q + ADDR_W'(1);
                        rd_d   = mem[addr_d][6:0];
                        miso_d = mem[addr_d][7];
                    end else begin
                        rd_d   = {rd_q[5:0], 1'b0};
                        miso_d = rd_q[6];
                    end
                end
                WDATA: begin
                    k_d  = {3'b100, 3'(k_q[2:0] + 3'd1)};
                    sh_d = {sh_q[5:0], bus.spi_mosi};
                    if (k_q[2:0] == 3'd7) begin
                        wr_en_c = 1'b1;
                        addr_d  = addr_q + ADDR_W'(1);
                    end
                end
                IGNORE: begin
                    state_d = IGNORE;
                end
                default: begin
                    state_d = IDLE;
                    k_d     = '0;
                end
            endcase
        end
    end

    assign bus.spi_miso = miso_q;
    assign bus.busy     = busy_q;

endmodule

// File: doc/nanov_spi_ram.md
# nanoV_spi_ram

SPI RAM responder for the nanoV CPU's SPI bus: the target end of the CPU's `spi_select`/`spi_out`/`spi_data_in` link. It decodes serial READ/WRITE commands and serves bytes from an internal byte array. It is used in simulation and FPGA builds as the CPU's program and data store. Bits move one per `clk` cycle while select is low, matching the CPU's system-clock-rate SPI.

## Interface
Parameters:
- `MEM_BYTES`, 256: array size in bytes; power of 2, 4..65536.
- `ADDR_W`, 8: log2(`MEM_BYTES`).

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `spi_select` in 1: chip select from CPU, active low.
- `spi_mosi` in 1: serial data from CPU (CPU `spi_out`), MSB first.
- `spi_miso` out 1: serial data to CPU (CPU `spi_data_in`), registered.
- `load_en` in 1: backdoor byte write strobe.
- `load_addr` in `ADDR_W`: backdoor address.
- `load_data` in 8: backdoor data.
- `busy` out 1: high while a transaction is past IDLE.

## Operation
- Bit counter `k` counts rising edges with `spi_select`=0, starting at 0 on the first such edge.
- States:
  - IDLE: go to CMD when select falls.
  - CMD: bits k=0..7 form the opcode. At k=7:
    - 0x03 goes to ADDR as READ.
    - 0x02 goes to ADDR as WRITE.
    - Any other value goes to IGNORE.
  - ADDR: bits k=8..31 form a 24-bit address. Only the low `ADDR_W` bits are used; upper bits are ignored.
  - RDATA: streams mem[addr] MSB first. After each 8 bits, addr increments modulo `MEM_BYTES`. Wrap from `MEM_BYTES`-1 to 0 is seamless.
  - WDATA: shifts in bits. On the 8th bit of each byte, writes mem[addr] and increments addr with the same wrap.
  - IGNORE: holds until deselect; `spi_miso`=0.
- `spi_select`=1 on any edge returns the block to IDLE. A partial write byte is discarded; completed bytes persist.
- Select deasserted mid-command or mid-address: no memory effect.
- Backdoor: `load_en`=1 writes `load_data` to mem[`load_addr`] on that edge, in any state. If an SPI byte write and a backdoor write hit the same address on the same edge, the SPI write wins.
- `busy` = state ≠ IDLE.

## Timing
- Reset: state IDLE, `spi_miso`=0, `busy`=0, `k`=0. Memory contents are not cleared.
- `rst` overrides a transaction in progress: IDLE next cycle, with no write for the in-flight byte.
- READ latency: the address's last bit is sampled at edge k=31. Bit 7 of mem[addr] appears on `spi_miso` after edge 31, valid for sampling at edge 32. Bit i of data byte n is sampled by the CPU at edge 32+8n+(7−i).
- Continuous read: byte n+1 bit 7 follows byte n bit 0 with no gap.
- WRITE: byte n is captured from MOSI at edges 32+8n..39+8n and committed at edge 39+8n. A READ of that address in a later transaction returns the new value.
- `spi_miso` is 0 outside RDATA/FASTDUMMY-to-RDATA output, and one cycle after deselect.
- Back-to-back transactions: select may reassert on the edge after the deselect edge. A new CMD starts with `k`=0.

## Configuration
- `NANOV_SPI_FAST_READ_EN`: decodes opcode 0x0B (FAST READ).
- With the macro, the sequence is CMD → ADDR → FASTDUMMY → RDATA.
  - FASTDUMMY is 8 cycles at k=32..39, with MOSI ignored and `spi_miso`=0.
  - Data bit 7 is then sampled at edge 40 and the stream continues as for READ.
- Without the macro, 0x0B is treated as unknown and goes to IGNORE.

## Test plan
- Backdoor load mem[0x10..0x13]=0x13,0x05,0x00,0x93; READ 0x03 address 0x000010 for 32 data bits. The CPU must shift in 0x13050093, first bit at edge 32.
- WRITE 0x02 address 0x000020 with data 0xA5,0x5A, then deselect, then READ 0x20. The READ must return 0xA5,0x5A; mem[0x22] must be unchanged.
- Wrap: READ starting at address 0x0000FF with `MEM_BYTES`=256 for 2 bytes. Must return mem[0xFF] then mem[0x00]. Address 0x1234FF must behave identically.
- Abort: WRITE to 0x30 with 5 data bits, then deselect. mem[0x30] is unchanged and `busy`=0 one edge after deselect. Opcode 0x9F gives `spi_miso`=0 throughout.
- Reset mid-READ at k=36: `spi_miso`=0 and `busy`=0 next cycle. A new READ afterwards returns correct data.
- With `NANOV_SPI_FAST_READ_EN`: 0x0B at address 0x10 with 8 dummy cycles returns 0x13 with first bit at edge 40. Without the macro, 0x0B gives `spi_miso`=0 throughout.
